cop_host_if: RTL

COP_HOST_IF -- requirements
Module: cop_host_if

---
 rtl/cop_host_if_if.sv | 38 +++
 rtl/cop_host_if.sv | 118 +++++++++++
 2 files changed

// File: rtl/cop_host_if_if.sv
// rtl/cop_host_if_if.sv - host/coprocessor handshake and shared-bus arbitration signal bundle
interface cop_host_if_if #(
    parameter int IDX_W = 8
);
    logic             i_Cmd_Valid;
    logic [IDX_W-1:0] i_Cmd_Row;
    logic [IDX_W-1:0] i_Cmd_Col;
    logic [IDX_W-1:0] i_Cmd_Mu;
    logic             o_Cmd_Ready;
    logic [IDX_W-1:0] o_Row_Index;
    logic [IDX_W-1:0] o_Column_Index;
    logic [IDX_W-1:0] o_mu;
    logic             o_Indexes_Ready;
    logic             i_Indexes_Received;
    logic             i_Grant_Request;
    logic             o_Grant;
    logic             i_Host_Bus_Busy;
    logic             i_Result_Ready;
    logic             o_Done;
    logic             o_Error;
    logic [15:0]      o_Job_Count;

    // Host and coprocessor side: drives every i_* signal, observes every o_* signal.
    modport master (
        output i_Cmd_Valid, i_Cmd_Row, i_Cmd_Col, i_Cmd_Mu,
        output i_Indexes_Received, i_Grant_Request, i_Host_Bus_Busy, i_Result_Ready,
        input  o_Cmd_Ready, o_Row_Index, o_Column_Index, o_mu, o_Indexes_Ready,
        input  o_Grant, o_Done, o_Error, o_Job_Count
    );

    // Interface block side.
    modport slave (
        input  i_Cmd_Valid, i_Cmd_Row, i_Cmd_Col, i_Cmd_Mu,
        input  i_Indexes_Received, i_Grant_Request, i_Host_Bus_Busy, i_Result_Ready,
        output o_Cmd_Ready, o_Row_Index, o_Column_Index, o_mu, o_Indexes_Ready,
        output o_Grant, o_Done, o_Error, o_Job_Count
    );
endinterface

// File: rtl/cop_host_if.sv
// rtl/cop_host_if.sv - host-to-coprocessor job dispatcher with timeout abort and shared-bus grant
module cop_host_if #(
    parameter int TIMEOUT = 255,
    parameter int IDX_W   = 8
) (
    input  logic          i_Clock,
    input  logic          i_Reset,
    cop_host_if_if.slave  host
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Last cycle a SEND or WAIT_RES visit may last; an acknowledge here still wins.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_RES,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             grant_q, grant_d;
    logic [15:0]      job_count_q, job_count_d;
    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic [IDX_W-1:0] mu_q, mu_d;

    logic in_job;
    logic expired;

    assign in_job  = (state_q == S_SEND) || (state_q == S_WAIT_RES);
    assign expired = (cnt_q == CNT_LAST);

    // Next-state, job latch, timeout counter and grant decisions.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        grant_d     = 1'b0;
        job_count_d = job_count_q;
        row_d       = row_q;
        col_d       = col_q;
        mu_d        = mu_q;

        case (state_q)
            S_IDLE: begin
                if (host.i_Cmd_Valid) begin
                    row_d   = host.i_Cmd_Row;
                    col_d   = host.i_Cmd_Col;
                    mu_d    = host.i_Cmd_Mu;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (host.i_Indexes_Received) begin
                    state_d = S_WAIT_RES;
                end else if (expired) begin
                    state_d = S_ERR;
                end
            end
            S_WAIT_RES: begin
                if (host.i_Result_Ready) begin
                    state_d     = S_DONE;
                    job_count_d = job_count_q + 16'd1;
                end else if (expired) begin
                    state_d = S_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The counter restarts from zero on every state change.
        if (in_job && (state_d == state_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Once granted, the CU keeps the bus until it withdraws its request,
        // even if the host becomes busy; no grant outside an active job.
        if (in_job) begin
            grant_d = grant_q ? host.i_Grant_Request
                              : (host.i_Grant_Request && !host.i_Host_Bus_Busy);
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            grant_q     <= 1'b0;
            job_count_q <= 16'd0;
            row_q       <= '0;
            col_q       <= '0;
            mu_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            job_count_q <= job_count_d;
            row_q       <= row_d;
            col_q       <= col_d;
            mu_q        <= mu_d;
        end
    end

    assign host.o_Cmd_Ready     = (state_q == S_IDLE);
    assign host.o_Indexes_Ready = (state_q == S_SEND);
    assign host.o_Done          = (state_q == S_DONE);
    assign host.o_Error         = (state_q == S_ERR);
    assign host.o_Grant         = grant_q;
    assign host.o_Job_Count     = job_count_q;
    assign host.o_Row_Index     = row_q;
    assign host.o_Column_Index  = col_q;
    assign host.o_mu            = mu_q;
endmodule
